// File: rtl/acq_pkg.sv
// Shared types for the multi-shot acquisition sequencer.
//   t_acq_state : FSM state, encoded as exported on state_o
//   t_sample    : one 64-bit sample word (4 channels x 16 bit)
package acq_pkg;

  localparam int unsigned SAMPLE_W = 64;

  typedef logic [SAMPLE_W-1:0] t_sample;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE_TRIG  = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST_TRIG = 3'd3,
    ST_SHOT_END  = 3'd4
  } t_acq_state;

endpackage

// File: rtl/acq_shot_sequencer.sv
// Multi-shot acquisition sequencer between the ADC deserialiser and the DDR
// write FIFO. Each shot occupies pre+post sample words in DDR; the pre-trigger
// region is a circular buffer until the trigger arrives.
// Ports:
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   start_i, stop_i, trig_i  1-cycle control pulses (stop has priority)
//   pre/post_samples_i,
//   nshots_i                 shot configuration, latched on an accepted start
//   sample_valid_i, sample_i incoming sample stream
//   wr_full_i                downstream FIFO full
//   wr_en_o/addr_o/data_o    registered DDR write request
//   state_o, shot_cnt_o      FSM state and shots remaining
//   shot_done_o, shot_trig_pos_o  end-of-shot pulse and oldest pre-sample address
//   acq_end_o, cfg_err_o     end-of-acquisition and rejected-start pulses
//   overflow_o               sticky sample-lost flag, cleared by an accepted start
module acq_shot_sequencer
  import acq_pkg::*;
#(
  parameter int unsigned G_ADDR_W = 25,
  parameter int unsigned G_SHOT_W = 16,
  parameter int unsigned G_CNT_W  = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                trig_i,
  input  logic [G_CNT_W-1:0]  pre_samples_i,
  input  logic [G_CNT_W-1:0]  post_samples_i,
  input  logic [G_SHOT_W-1:0] nshots_i,
  input  logic                sample_valid_i,
  input  t_sample             sample_i,
  input  logic                wr_full_i,
  output logic                wr_en_o,
  output logic [G_ADDR_W-1:0] wr_addr_o,
  output t_sample             wr_data_o,
  output logic [2:0]          state_o,
  output logic [G_SHOT_W-1:0] shot_cnt_o,
  output logic                shot_done_o,
  output logic [G_ADDR_W-1:0] shot_trig_pos_o,
  output logic                acq_end_o,
  output logic                cfg_err_o,
  output logic                overflow_o
);

  t_acq_state          state;
  logic [G_CNT_W-1:0]  pre_r;
  logic [G_CNT_W-1:0]  post_r;
  logic [G_CNT_W-1:0]  pre_ptr;
  logic [G_CNT_W-1:0]  post_cnt;
  logic [G_ADDR_W-1:0] base_addr;

  logic [G_CNT_W-1:0]  pre_idx;
  logic [G_CNT_W-1:0]  pre_next;
  logic [G_ADDR_W-1:0] pre_addr;
  logic [G_ADDR_W-1:0] post_addr;
  logic [G_ADDR_W-1:0] shot_span;
  logic                sample_lost;

  // pre_ptr == pre_r means the pre region was just filled: the next write
  // (and the oldest sample) is at slot 0. Also covers pre=0.
  always_comb begin
    pre_idx     = (pre_ptr == pre_r) ? '0 : pre_ptr;
    pre_next    = pre_idx + G_CNT_W'(1);
    pre_addr    = base_addr + G_ADDR_W'(pre_idx);
    post_addr   = base_addr + G_ADDR_W'(pre_r) + G_ADDR_W'(post_cnt);
    shot_span   = G_ADDR_W'(pre_r + post_r);
    sample_lost = sample_valid_i && wr_full_i;
  end

  assign state_o = state;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= ST_IDLE;
      pre_r           <= '0;
      post_r          <= '0;
      pre_ptr         <= '0;
      post_cnt        <= '0;
      base_addr       <= '0;
      shot_cnt_o      <= '0;
      wr_en_o         <= 1'b0;
      wr_addr_o       <= '0;
      wr_data_o       <= '0;
      shot_done_o     <= 1'b0;
      shot_trig_pos_o <= '0;
      acq_end_o       <= 1'b0;
      cfg_err_o       <= 1'b0;
      overflow_o      <= 1'b0;
    end else begin
      wr_en_o     <= 1'b0;
      shot_done_o <= 1'b0;
      acq_end_o   <= 1'b0;
      cfg_err_o   <= 1'b0;

      if (stop_i) begin
        state <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start_i) begin
              if (nshots_i == '0 || post_samples_i == '0) begin
                cfg_err_o <= 1'b1;
              end else begin
                pre_r      <= pre_samples_i;
                post_r     <= post_samples_i;
                shot_cnt_o <= nshots_i;
                base_addr  <= '0;
                pre_ptr    <= '0;
                post_cnt   <= '0;
                overflow_o <= 1'b0;
                state      <= (pre_samples_i == '0) ? ST_WAIT_TRIG : ST_PRE_TRIG;
              end
            end
          end

          ST_PRE_TRIG, ST_WAIT_TRIG: begin
            if (sample_lost) begin
              overflow_o <= 1'b1;
              state      <= ST_IDLE;
            end else if (state == ST_WAIT_TRIG && trig_i) begin
              // A sample arriving with the trigger is post sample 0.
              state <= ST_POST_TRIG;
              if (sample_valid_i) begin
                wr_en_o   <= 1'b1;
                wr_addr_o <= post_addr;
                wr_data_o <= sample_i;
                post_cnt  <= G_CNT_W'(1);
                if (post_r == G_CNT_W'(1)) state <= ST_SHOT_END;
              end
            end else if (sample_valid_i && pre_r != '0) begin
              wr_en_o   <= 1'b1;
              wr_addr_o <= pre_addr;
              wr_data_o <= sample_i;
              pre_ptr   <= pre_next;
              if (pre_next == pre_r) state <= ST_WAIT_TRIG;
            end
          end

          ST_POST_TRIG: begin
            if (sample_lost) begin
              overflow_o <= 1'b1;
              state      <= ST_IDLE;
            end else if (sample_valid_i) begin
              wr_en_o   <= 1'b1;
              wr_addr_o <= post_addr;
              wr_data_o <= sample_i;
              post_cnt  <= post_cnt + G_CNT_W'(1);
              if (post_cnt + G_CNT_W'(1) == post_r) state <= ST_SHOT_END;
            end
          end

          ST_SHOT_END: begin
            shot_done_o     <= 1'b1;
            shot_trig_pos_o <= pre_addr;
            base_addr       <= base_addr + shot_span;
            shot_cnt_o      <= shot_cnt_o - G_SHOT_W'(1);
            pre_ptr         <= '0;
            post_cnt        <= '0;
            if (shot_cnt_o == G_SHOT_W'(1)) begin
              acq_end_o <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              state <= (pre_r == '0) ? ST_WAIT_TRIG : ST_PRE_TRIG;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acq_shot_sequencer.sv
// Self-checking bench for acq_shot_sequencer: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// shot-level behavioural model.
module tb_acq_shot_sequencer;
  import acq_pkg::*;

  localparam int unsigned AW = 25;
  localparam int unsigned SW = 16;
  localparam int unsigned CW = 32;
  localparam longint AMASK = (64'd1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, trig = 1'b0;
  logic [CW-1:0] pre_samples = '0, post_samples = '0;
  logic [SW-1:0] nshots = '0;
  logic          valid = 1'b0, full = 1'b0;
  t_sample       sample = '0;

  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  t_sample       wr_data_o;
  logic [2:0]    state_o;
  logic [SW-1:0] shot_cnt_o;
  logic          shot_done_o;
  logic [AW-1:0] shot_trig_pos_o;
  logic          acq_end_o, cfg_err_o, overflow_o;

  acq_shot_sequencer #(.G_ADDR_W(AW), .G_SHOT_W(SW), .G_CNT_W(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop), .trig_i(trig),
    .pre_samples_i(pre_samples), .post_samples_i(post_samples), .nshots_i(nshots),
    .sample_valid_i(valid), .sample_i(sample), .wr_full_i(full),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .state_o(state_o), .shot_cnt_o(shot_cnt_o), .shot_done_o(shot_done_o),
    .shot_trig_pos_o(shot_trig_pos_o), .acq_end_o(acq_end_o),
    .cfg_err_o(cfg_err_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // ---------------- behavioural model (shot level) ----------------
  bit      m_active = 0, m_trig = 0, m_in_end = 0, m_ovf = 0;
  longint  m_pre = 0, m_post = 0, m_left = 0, m_base = 0, m_seen = 0, m_got = 0;
  bit      e_wr_en = 0, e_done = 0, e_end = 0, e_cfg = 0;
  longint  e_addr = 0, e_pos = 0;
  t_sample e_data = '0;
  int      e_state = 0;

  task automatic put(input longint a);
    e_wr_en = 1;
    e_addr  = a & AMASK;
    e_data  = sample;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 0; m_trig = 0; m_in_end = 0; m_ovf = 0;
        m_pre = 0; m_post = 0; m_left = 0; m_base = 0; m_seen = 0; m_got = 0;
        e_wr_en = 0; e_done = 0; e_end = 0; e_cfg = 0; e_state = 0;
      end else begin
        e_wr_en = 0; e_done = 0; e_end = 0; e_cfg = 0;
        if (stop) begin
          m_active = 0; m_in_end = 0;
        end else if (!m_active) begin
          if (start) begin
            if (nshots == 0 || post_samples == 0) e_cfg = 1;
            else begin
              m_pre = pre_samples; m_post = post_samples; m_left = nshots;
              m_base = 0; m_seen = 0; m_trig = 0; m_got = 0;
              m_in_end = 0; m_ovf = 0; m_active = 1;
            end
          end
        end else if (m_in_end) begin
          e_done = 1;
          e_pos  = (m_pre == 0) ? m_base : ((m_base + m_seen % m_pre) & AMASK);
          m_base = (m_base + m_pre + m_post) & AMASK;
          m_left--;
          m_in_end = 0; m_seen = 0; m_trig = 0; m_got = 0;
          if (m_left == 0) begin m_active = 0; e_end = 1; end
        end else if (valid && full) begin
          m_ovf = 1; m_active = 0;
        end else if (!m_trig && trig && m_seen >= m_pre) begin
          m_trig = 1;
          if (valid) begin
            put(m_base + m_pre);
            m_got = 1;
            if (m_got == m_post) m_in_end = 1;
          end
        end else if (!m_trig && valid && m_pre != 0) begin
          put(m_base + m_seen % m_pre);
          m_seen++;
        end else if (m_trig && valid) begin
          put(m_base + m_pre + m_got);
          m_got++;
          if (m_got == m_post) m_in_end = 1;
        end
        e_state = !m_active ? 0 : m_in_end ? 4 : m_trig ? 3 : (m_seen < m_pre) ? 1 : 2;
      end
    end
  end

  // ---------------- compare process + logs for literal checks ----------------
  bit     chk_en = 0;
  longint wlog[$];
  longint dlog[$];
  int     acq_cnt = 0, cfg_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("wr_en", wr_en_o, e_wr_en);
      if (e_wr_en) begin
        check("wr_addr", wr_addr_o, e_addr);
        check("wr_data", wr_data_o, e_data);
      end
      check("shot_done", shot_done_o, e_done);
      if (e_done) check("trig_pos", shot_trig_pos_o, e_pos);
      check("acq_end", acq_end_o, e_end);
      check("cfg_err", cfg_err_o, e_cfg);
      check("overflow", overflow_o, m_ovf);
      check("state", state_o, e_state);
      check("shot_cnt", shot_cnt_o, m_left);
      if (wr_en_o) wlog.push_back(longint'(wr_addr_o));
      if (shot_done_o) dlog.push_back(longint'(shot_trig_pos_o));
      if (acq_end_o) acq_cnt++;
      if (cfg_err_o) cfg_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit st, input bit sp, input bit tr, input bit v, input bit fl);
    start = st; stop = sp; trig = tr; valid = v; full = fl;
    sample = {$urandom, $urandom};
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic feed(input int n);
    repeat (n) step(0, 0, 0, 1, 0);
  endtask

  task automatic cfg(input int p, input int q, input int n);
    pre_samples = CW'(p); post_samples = CW'(q); nshots = SW'(n);
  endtask

  task automatic clear_logs();
    wlog.delete(); dlog.delete(); acq_cnt = 0; cfg_cnt = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    // reset state, literal
    check("rst_wr_en", wr_en_o, 0);
    check("rst_addr", wr_addr_o, 0);
    check("rst_data", wr_data_o, 0);
    check("rst_state", state_o, 0);
    check("rst_shot_cnt", shot_cnt_o, 0);
    check("rst_done", shot_done_o, 0);
    check("rst_pos", shot_trig_pos_o, 0);
    check("rst_end", acq_end_o, 0);
    check("rst_cfg", cfg_err_o, 0);
    check("rst_ovf", overflow_o, 0);
    rst_n = 1'b1;
    chk_en = 1;
    idle(2);

    // pre=0 post=16 one shot
    clear_logs(); cfg(0, 16, 1);
    step(1, 0, 0, 0, 0);
    feed(3);
    step(0, 0, 1, 0, 0);
    feed(16);
    idle(4);
    check("s1_nwr", wlog.size(), 16);
    if (wlog.size() == 16) begin
      check("s1_first", wlog[0], 0);
      check("s1_last", wlog[15], 15);
    end
    check("s1_ndone", dlog.size(), 1);
    if (dlog.size() == 1) check("s1_pos", dlog[0], 0);
    check("s1_acq_end", acq_cnt, 1);

    // pre=4 post=4 three shots, 10 pre-trigger samples each
    clear_logs(); cfg(4, 4, 3);
    step(1, 0, 0, 0, 0);
    repeat (3) begin
      feed(10);
      step(0, 0, 1, 0, 0);
      feed(4);
      idle(2);
    end
    idle(3);
    check("s2_nwr", wlog.size(), 42);
    if (wlog.size() == 42) begin
      check("s2_wrap", wlog[4], 0);
      check("s2_pre9", wlog[9], 1);
      check("s2_post0", wlog[10], 4);
      check("s2_shot1", wlog[24], 12);
      check("s2_shot2", wlog[28], 16);
    end
    check("s2_ndone", dlog.size(), 3);
    if (dlog.size() == 3) begin
      check("s2_pos0", dlog[0], 2);
      check("s2_pos1", dlog[1], 10);
      check("s2_pos2", dlog[2], 18);
    end
    check("s2_acq_end", acq_cnt, 1);
    check("s2_shot_cnt", shot_cnt_o, 0);

    // rejected starts
    clear_logs(); cfg(3, 5, 0);
    step(1, 0, 0, 0, 0);
    feed(3);
    cfg(3, 0, 2);
    step(1, 0, 0, 0, 0);
    feed(2);
    check("s3_cfg_err", cfg_cnt, 2);
    check("s3_state", state_o, 0);
    check("s3_nwr", wlog.size(), 0);

    // trigger with sample in WAIT_TRIG
    clear_logs(); cfg(2, 3, 1);
    step(1, 0, 0, 0, 0);
    feed(3);
    step(0, 0, 1, 1, 0);
    feed(2);
    idle(4);
    check("s4_nwr", wlog.size(), 6);
    if (wlog.size() == 6) check("s4_trig_sample", wlog[3], 2);
    if (dlog.size() == 1) check("s4_pos", dlog[0], 1);
    else check("s4_ndone", dlog.size(), 1);

    // overflow mid POST_TRIG, cleared by next accepted start
    clear_logs(); cfg(1, 8, 1);
    step(1, 0, 0, 0, 0);
    feed(2);
    step(0, 0, 1, 0, 0);
    feed(3);
    step(0, 0, 0, 1, 1);
    idle(2);
    check("s5_overflow", overflow_o, 1);
    check("s5_state", state_o, 0);
    check("s5_acq_end", acq_cnt, 0);
    check("s5_nwr", wlog.size(), 5);
    cfg(1, 2, 1);
    step(1, 0, 0, 0, 0);
    check("s5_ovf_clear", overflow_o, 0);
    step(0, 1, 0, 0, 0);
    idle(3);

    // stop in WAIT_TRIG of shot 2 of 3; trig in PRE_TRIG ignored
    clear_logs(); cfg(2, 2, 3);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    feed(1);
    step(0, 0, 1, 0, 0);
    feed(2);
    idle(2);
    feed(2);
    step(0, 1, 1, 0, 0);
    idle(3);
    check("s6_acq_end", acq_cnt, 0);
    check("s6_ndone", dlog.size(), 1);
    check("s6_state", state_o, 0);
    check("s6_shot_cnt", shot_cnt_o, 2);
    check("s6_nwr", wlog.size(), 6);
    if (wlog.size() == 6) begin
      check("s6_pre0", wlog[0], 0);
      check("s6_post0", wlog[2], 2);
    end

    // randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      cfg($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 3));
      step(($urandom_range(0, 99) < 6), ($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 65),
           ($urandom_range(0, 99) < 2));
    end
    step(0, 1, 0, 0, 0);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
